// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: RV32I branch condition codes and the
// saturating counter update used by the pattern history table.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Widest counter the helper can handle; callers narrow the result back.
  localparam int unsigned CNT_MAX_W = 16;

  // Step a cnt_w-bit counter toward taken/not-taken, clamping at both ends.
  function automatic logic [CNT_MAX_W-1:0] sat_update(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic                 taken,
    input int unsigned          cnt_w
  );
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
    if (taken) begin
      return (cnt >= max_v) ? max_v : cnt + CNT_MAX_W'(1);
    end
    return (cnt == '0) ? '0 : cnt - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_pht_table.sv
// Pattern history table: saturating direction counters with one
// combinational lookup port and one clocked update port.
module pht_table
  import branch_pkg::*;
#(
  parameter int unsigned  PHT_DEPTH = 64,
  parameter int unsigned  CNT_W     = 2,
  localparam int unsigned IDX_W     = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  // Weakly-not-taken reset value: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

  logic [CNT_W-1:0] cnt_q [PHT_DEPTH];
  logic [CNT_W-1:0] upd_cnt_d;

  // Lookup reads the registered array directly, so a same-cycle update is not visible.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    upd_cnt_d = CNT_W'(sat_update(CNT_MAX_W'(cnt_q[upd_idx_i]), upd_taken_i, CNT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, PHT-based direction prediction at fetch, mispredict
// detection and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              branch,
  input  logic              jump,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              ex_pred_taken,
  output logic              pc_src,
  output logic              mispredict,
  output logic              illegal_branch,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

  logic             cond_c;
  logic             legal_c;
  logic             upd_c;
  logic [IDX_W-1:0] fetch_idx_c;
  logic [IDX_W-1:0] ex_idx_c;
  logic [CNT_W-1:0] rd_cnt_c;

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] misp_cnt_q, misp_cnt_d;

  // Branch condition decode; the two reserved encodings never take.
  always_comb begin
    cond_c  = 1'b0;
    legal_c = 1'b1;
    case (funct3)
      F3_BEQ:  cond_c = zero;
      F3_BNE:  cond_c = ~zero;
      F3_BLT:  cond_c = lt;
      F3_BGE:  cond_c = ~lt;
      F3_BLTU: cond_c = ltu;
      F3_BGEU: cond_c = ~ltu;
      default: legal_c = 1'b0;
    endcase
  end

  assign upd_c          = ex_valid & branch & legal_c;
  assign pc_src         = (upd_c & cond_c) | (ex_valid & jump);
  assign mispredict     = upd_c & (cond_c ^ ex_pred_taken);
  assign illegal_branch = ex_valid & branch & ~legal_c;

  // Word-aligned PCs: drop the two byte-offset bits before indexing.
  assign fetch_idx_c = fetch_pc[IDX_W+1:2];
  assign ex_idx_c    = ex_pc[IDX_W+1:2];

  pht_table #(
    .PHT_DEPTH (PHT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_pht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (fetch_idx_c),
    .rd_cnt_o    (rd_cnt_c),
    .upd_en_i    (upd_c),
    .upd_idx_i   (ex_idx_c),
    .upd_taken_i (cond_c)
  );

  assign pred_taken = rd_cnt_c[CNT_W-1];

  // Statistics stick at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (upd_c && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + STAT_W'(1);
    end
    if (mispredict && (misp_cnt_q != '1)) begin
      misp_cnt_d = misp_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = misp_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0], rd_cnt_c[CNT_W-2:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit (PHT_DEPTH=64, CNT_W=2, STAT_W=4).
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc, ex_pc;
  logic        pred_taken, ex_valid, branch, jump, zero, lt, ltu, ex_pred_taken;
  logic [2:0]  funct3;
  logic        pc_src, mispredict, illegal_branch;
  logic [3:0]  branch_count, mispredict_count;

  branch_predict_unit #(
    .XLEN(32), .PHT_DEPTH(64), .CNT_W(2), .STAT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .branch(branch), .jump(jump),
    .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .ex_pred_taken(ex_pred_taken), .pc_src(pc_src), .mispredict(mispredict),
    .illegal_branch(illegal_branch), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       src;
    logic       misp;
    logic       ill;
    logic       pred;
    logic [3:0] bcnt;
    logic [3:0] mcnt;
  } res_t;

  typedef struct {
    string name;
    res_t  exp;
  } sb_t;

  sb_t  sb[$];
  sb_t  e;
  res_t o;
  int   total = 0;
  int   bad = 0;

  // Reference model state: 2-bit counters per entry plus saturating stats.
  int m_pht[64];
  int m_b, m_m;

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic m_cond(output logic legal);
    legal = 1'b1;
    case (funct3)
      3'b000: return zero;
      3'b001: return !zero;
      3'b100: return lt;
      3'b101: return !lt;
      3'b110: return ltu;
      3'b111: return !ltu;
      default: begin legal = 1'b0; return 1'b0; end
    endcase
  endfunction

  function automatic res_t model();
    res_t r;
    logic legal, c;
    c      = m_cond(legal);
    r.src  = (ex_valid & branch & legal & c) | (ex_valid & jump);
    r.misp = ex_valid & branch & legal & (c != ex_pred_taken);
    r.ill  = ex_valid & branch & !legal;
    r.pred = (m_pht[idx(fetch_pc)] >= 2);
    r.bcnt = 4'(m_b);
    r.mcnt = 4'(m_m);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_b = 0;
    m_m = 0;
  endfunction

  function automatic void model_commit();
    logic legal, c;
    int   i;
    c = m_cond(legal);
    if (rst_n && ex_valid && branch && legal) begin
      i = idx(ex_pc);
      if (c) m_pht[i] = (m_pht[i] < 3) ? m_pht[i] + 1 : 3;
      else   m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
      if (m_b < 15) m_b++;
      if ((c != ex_pred_taken) && (m_m < 15)) m_m++;
    end
  endfunction

  function automatic res_t observe();
    res_t r;
    r.src  = pc_src;
    r.misp = mispredict;
    r.ill  = illegal_branch;
    r.pred = pred_taken;
    r.bcnt = branch_count;
    r.mcnt = mispredict_count;
    return r;
  endfunction

  // Apply stimulus and queue the model's expectation for this cycle.
  task automatic drive(input string nm, input logic v, input logic br, input logic jp,
                       input logic [2:0] f3, input logic z, input logic l, input logic lu,
                       input logic pt, input logic [31:0] epc, input logic [31:0] fpc);
    ex_valid = v; branch = br; jump = jp; funct3 = f3;
    zero = z; lt = l; ltu = lu; ex_pred_taken = pt;
    ex_pc = epc; fetch_pc = fpc;
    sb.push_back('{nm, model()});
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b0; branch = 1'b0; jump = 1'b0;
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h100; pcs[2] = 32'hFC;
    for (int i = 0; i < 2; i++) begin
      drive("pre_reset_train", 1, 1, 0, F3_BEQ, 1, 0, 0, 0, 32'h100, 32'h100);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
      tick();
    end
    // Reset lands mid-cycle while an update is still being presented.
    rst_n = 1'b0;
    #1 model_reset();
    for (int i = 0; i < 3; i++) begin
      drive($sformatf("in_reset_pc%0h", pcs[i]), 1, 1, 0, F3_BEQ, 1, 0, 0, 0, 32'h100, pcs[i]);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp || pred_taken !== 1'b0 || branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
    end
    tick();
    rst_n = 1'b1;
    drive("post_reset_discard", 0, 0, 0, F3_BEQ, 0, 0, 0, 0, 32'h100, 32'h100);
    #1 e = sb.pop_front(); o = observe(); total++;
    if (o !== e.exp || pred_taken !== 1'b0 || branch_count !== 4'd0) begin
      bad++;
      $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
    end
    tick();
  endtask

  task automatic test_cond_sweep();
    logic [2:0] f3 [7];
    logic [6:0] z, l, lu, src, ill;
    f3[0] = F3_BEQ; f3[1] = F3_BNE; f3[2] = F3_BLT; f3[3] = F3_BGE;
    f3[4] = F3_BLTU; f3[5] = F3_BGEU; f3[6] = 3'b010;
    z   = 7'b0000011;
    l   = 7'b0001100;
    lu  = 7'b0000000;
    src = 7'b0100101;
    ill = 7'b1000000;
    for (int i = 0; i < 7; i++) begin
      drive($sformatf("cond_f3_%0d", f3[i]), 1, 1, 0, f3[i], z[i], l[i], lu[i], 0,
            32'h200 + 32'(i * 4), 32'h200);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp || pc_src !== src[i] || illegal_branch !== ill[i]) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b lit_src=%b lit_ill=%b",
                 e.name, o, e.exp, src[i], ill[i]);
      end
      tick();
    end
    drive("after_illegal", 0, 0, 0, F3_BEQ, 0, 0, 0, 0, 32'h0, 32'h200);
    #1 e = sb.pop_front(); o = observe(); total++;
    if (o !== e.exp || branch_count !== 4'd6 || mispredict_count !== 4'd3) begin
      bad++;
      $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
    end
    tick();
  endtask

  task automatic test_training();
    logic [6:0] z, pt;
    z  = 7'b0111111;
    pt = 7'b1111100;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive($sformatf("train_%0d", i), 1, 1, 0, F3_BEQ, z[i], 0, 0, pt[i], 32'h40, 32'h40);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
      tick();
      if (i == 1) begin
        total++;
        if (pred_taken !== 1'b1 || branch_count !== 4'd2 || mispredict_count !== 4'd2) begin
          bad++;
          $display("FAIL train_after2 got pred=%b bcnt=%0d mcnt=%0d want pred=1 bcnt=2 mcnt=2",
                   pred_taken, branch_count, mispredict_count);
        end
      end
    end
    total++;
    if (pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL train_hysteresis got pred=%b want pred=1", pred_taken);
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive("collide_same_cycle", 1, 1, 0, F3_BEQ, 1, 0, 0, 0, 32'h40, 32'h140);
      else        drive("collide_next_cycle", 0, 0, 0, F3_BEQ, 0, 0, 0, 0, 32'h40, 32'h140);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp || pred_taken !== 1'(i)) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
      tick();
    end
  endtask

  task automatic test_jump_gating();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive("jump", 1, 0, 1, F3_BEQ, 0, 0, 0, 1, 32'h80, 32'h80);
      else drive($sformatf("gated_%0d", i), 0, 1, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h80, 32'h80);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp || mispredict !== 1'b0 || pc_src !== (i == 0) ||
          illegal_branch !== 1'b0 || branch_count !== 4'd0) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i < 20) drive($sformatf("sat_%0d", i), 1, 1, 0, F3_BEQ, 1, 0, 0, 0, 32'(i * 4), 32'h0);
      else        drive("sat_final", 0, 0, 0, F3_BEQ, 0, 0, 0, 0, 32'h0, 32'h0);
      #1 e = sb.pop_front(); o = observe(); total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL %s [src,misp,ill,pred,bcnt,mcnt] got=%b want=%b", e.name, o, e.exp);
      end
      if (i == 20) begin
        total++;
        if (branch_count !== 4'd15 || mispredict_count !== 4'd15) begin
          bad++;
          $display("FAIL sat_counts got bcnt=%0d mcnt=%0d want 15 15", branch_count, mispredict_count);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = '0; ex_pc = '0; ex_valid = 1'b0; branch = 1'b0; jump = 1'b0;
    funct3 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; ex_pred_taken = 1'b0;
    model_reset();
    do_reset();
    test_reset();
    test_cond_sweep();
    test_training();
    test_collision();
    test_jump_gating();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch decision logic. It resolves all RV32I conditional branches plus jumps in the execute stage and adds a pattern history table (PHT) of saturating counters that predicts branch direction at fetch. It also flags mispredictions and keeps saturating branch/mispredict statistics. It sits between fetch (prediction lookup) and execute (resolution, PC redirect, flush).

## Interface
- XLEN, 32, width of PC.
- PHT_DEPTH, 64, number of PHT entries; power of two, ≥2; IDX_W = log2(PHT_DEPTH).
- CNT_W, 2, saturating counter width; ≥2.
- STAT_W, 32, width of statistics counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  predicted direction for fetch_pc.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  XLEN  PC of execute-stage instruction.
- branch  in  1  instruction is a conditional branch.
- jump  in  1  instruction is JAL/JALR.
- funct3  in  3  branch condition code.
- zero  in  1  ALU result zero (rs1 == rs2).
- lt  in  1  rs1 < rs2 signed.
- ltu  in  1  rs1 < rs2 unsigned.
- ex_pred_taken  in  1  prediction carried with the instruction from fetch.
- pc_src  out  1  actual redirect: taken branch or jump.
- mispredict  out  1  resolved branch direction ≠ ex_pred_taken.
- illegal_branch  out  1  branch with funct3 010/011.
- branch_count  out  STAT_W  resolved conditional branches.
- mispredict_count  out  STAT_W  mispredicted branches.

## Operation
- Condition decode: 000 BEQ zero; 001 BNE !zero; 100 BLT lt; 101 BGE !lt; 110 BLTU ltu; 111 BGEU !ltu; 010/011 → not taken, illegal_branch=1.
- All resolve outputs are gated by ex_valid; with ex_valid=0, pc_src, mispredict and illegal_branch are 0.
- taken = ex_valid & branch & legal & cond.
- pc_src = taken | (ex_valid & jump).
- mispredict = ex_valid & branch & legal & (cond ≠ ex_pred_taken).
- Jumps never touch the PHT or the statistics.
- Index = pc[IDX_W+1:2] for both fetch_pc and ex_pc.
- pred_taken = MSB of PHT[index(fetch_pc)].
- Update occurs on ex_valid & branch & legal: the counter increments if taken, otherwise decrements. It saturates at 2^CNT_W−1 and at 0.
- Illegal branches do not update the PHT and are not counted.
- Statistics:
  - branch_count +1 per legal resolved branch.
  - mispredict_count +1 when mispredict=1.
  - Both saturate at all-ones and do not wrap.

## Timing
- pc_src, mispredict, illegal_branch and pred_taken are combinational, with zero latency.
- PHT and statistics updates take effect at the next rising clk edge.
- Read/write collision: if fetch_pc and ex_pc index the same entry in the same cycle, pred_taken returns the old (pre-update) value. There is no bypass.
- Reset (asynchronous, any time):
  - every PHT entry is set to weakly-not-taken, i.e. 2^(CNT_W−1)−1 (01 for CNT_W=2);
  - both statistics counters are set to 0.
- Consequently pred_taken=0 for every PC after reset.
- A reset asserted mid-update discards that update.
- Outputs during reset follow their combinational definitions from the reset table contents.

## Structure
- Package branch_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - a function sat_update(cnt, taken) used by the table;
  - shared with the decoder.
- Sub-module pht_table (parameters PHT_DEPTH, CNT_W) contains:
  - the counter array with async reset;
  - one combinational read port and one synchronous saturating update port.
- Condition decode, mispredict logic and statistics live in the top level.

## Test plan
- Reset: assert rst_n=0 mid-cycle. Counters read 0 and pred_taken=0 for fetch_pc 0x0, 0x100, 0xFC. Clear table takes effect immediately, without waiting for an edge.
- Condition sweep:
  - BEQ zero=1 → pc_src=1; BNE zero=1 → 0.
  - BLT lt=1 → 1; BGE lt=1 → 0.
  - BLTU ltu=0 → 0; BGEU ltu=0 → 1.
  - funct3=010 → pc_src=0, illegal_branch=1, no counter change.
- Training: ex_pc=0x40 taken twice, ex_pred_taken=0. mispredict=1 then 1. Afterwards pred_taken(0x40)=1, mispredict_count=2, branch_count=2. Four more taken → counter 11 and stays. Then one not-taken → pred_taken still 1.
- Aliasing/collision (PHT_DEPTH=64): update ex_pc=0x40 while fetch_pc=0x140 in the same cycle. pred_taken shows the old value that cycle and the new value next cycle.
- Jump and gating: jump=1, ex_valid=1 → pc_src=1, mispredict=0, stats unchanged. Any inputs with ex_valid=0 → all resolve outputs 0 and no update.
- Saturation: STAT_W=4, 20 mispredicted branches → both counts 15.
